// File: rtl/fsm_bus_requester.sv
// Requester side of the req/gnt bus handshake: takes a beat-count/hold command,
// requests the bus, strobes one beat per granted cycle, then holds the grant.
module fsm_bus_requester #(
    parameter int LEN_W  = 4,
    parameter int HOLD_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [HOLD_W-1:0] cmd_hold,
    output logic              req,
    input  logic              gnt,
    output logic              done,
    output logic              dly,
    output logic              beat,
    output logic [LEN_W-1:0]  beat_idx,
    output logic              busy
);

    typedef enum logic [1:0] {
        R_IDLE,
        R_REQ,
        R_XFER,
        R_HOLD
    } state_t;

    state_t            state_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  bcnt_q;
    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hcnt_q;

    logic inBurst;
    logic lastBeat;

    // done and dly are Mealy so the arbiter sees them in the same cycle as the grant.
    assign inBurst   = (state_q == R_REQ) || (state_q == R_XFER);
    assign beat      = gnt && inBurst;
    assign lastBeat  = beat && (bcnt_q == len_q);
    assign done      = lastBeat;
    assign dly       = (lastBeat && (hold_q != '0)) || ((state_q == R_HOLD) && (hcnt_q != '0));
    assign req       = (state_q == R_REQ);
    assign busy      = (state_q != R_IDLE);
    assign beat_idx  = bcnt_q;
    assign cmd_ready = (state_q == R_IDLE) && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= R_IDLE;
            len_q   <= '0;
            hold_q  <= '0;
            bcnt_q  <= '0;
            hcnt_q  <= '0;
        end else begin
            case (state_q)
                R_IDLE: begin
                    if (cmd_valid) begin
                        len_q   <= cmd_len;
                        hold_q  <= cmd_hold;
                        bcnt_q  <= '0;
                        state_q <= R_REQ;
                    end
                end
                R_REQ, R_XFER: begin
                    if (gnt) begin
                        // At full length this wraps to zero harmlessly on the last beat.
                        bcnt_q <= bcnt_q + LEN_W'(1);
                        if (bcnt_q == len_q) begin
                            if (hold_q == '0) begin
                                state_q <= R_IDLE;
                            end else begin
                                hcnt_q  <= hold_q - HOLD_W'(1);
                                state_q <= R_HOLD;
                            end
                        end else begin
                            state_q <= R_XFER;
                        end
                    end
                end
                R_HOLD: begin
                    if (hcnt_q == '0) begin
                        state_q <= R_IDLE;
                    end else begin
                        hcnt_q <= hcnt_q - HOLD_W'(1);
                    end
                end
                default: state_q <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_bus_requester.sv
// Self-checking bench for fsm_bus_requester with a small arbiter model and a
// beat scoreboard; the bench can also drive gnt directly.
module tb_fsm_bus_requester;

    localparam int LEN_W  = 4;
    localparam int HOLD_W = 3;

    logic              clk;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [LEN_W-1:0]  cmd_len;
    logic [HOLD_W-1:0] cmd_hold;
    logic              req;
    logic              gnt;
    logic              done;
    logic              dly;
    logic              beat;
    logic [LEN_W-1:0]  beat_idx;
    logic              busy;

    logic useArb;
    logic tbGnt;
    logic arbGnt;

    int checks;
    int errors;
    int beatCount;

    typedef struct {
        int idx;
        bit last;
        bit dlyExp;
    } beat_t;

    beat_t sbQ[$];

    fsm_bus_requester #(
        .LEN_W(LEN_W),
        .HOLD_W(HOLD_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_len(cmd_len),
        .cmd_hold(cmd_hold),
        .req(req),
        .gnt(gnt),
        .done(done),
        .dly(dly),
        .beat(beat),
        .beat_idx(beat_idx),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Arbiter: grants the cycle after it samples req, releases after done
    // without dly, or on the first cycle it samples dly low while holding.
    typedef enum logic [1:0] {A_IDLE, A_BUSY, A_HOLD} arb_t;
    arb_t arbState;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            arbState <= A_IDLE;
        end else if (useArb) begin
            case (arbState)
                A_IDLE: if (req) arbState <= A_BUSY;
                A_BUSY: if (done) arbState <= dly ? A_HOLD : A_IDLE;
                A_HOLD: if (!dly) arbState <= A_IDLE;
                default: arbState <= A_IDLE;
            endcase
        end
    end

    assign arbGnt = (arbState != A_IDLE);
    assign gnt    = useArb ? arbGnt : tbGnt;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic pushBurst(input int len, input int hold);
        for (int i = 0; i <= len; i++) begin
            sbQ.push_back('{idx: i, last: (i == len), dlyExp: (i == len) && (hold != 0)});
        end
    endtask

    // Scoreboard side: every beat the DUT issues is matched against the queue.
    always @(negedge clk) begin
        if (!rst && beat) begin
            beat_t e;
            beatCount++;
            if (sbQ.size() == 0) begin
                checkOutput("sbUnexpectedBeat", 1, 0);
            end else begin
                e = sbQ.pop_front();
                checkOutput("sbBeatIdx", int'(beat_idx), e.idx);
                checkOutput("sbDone", int'(done), int'(e.last));
                checkOutput("sbDly", int'(dly), int'(e.dlyExp));
            end
        end
    end

    // Called just after a rising edge with the DUT idle; the accept cycle is N.
    task automatic applyStimulus(input int len, input int hold);
        int kEnd;
        kEnd      = 3 + len + hold;
        cmd_valid = 1'b1;
        cmd_len   = LEN_W'(len);
        cmd_hold  = HOLD_W'(hold);
        pushBurst(len, hold);
        @(negedge clk);
        checkOutput("acceptReady", int'(cmd_ready), 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_len   = ~cmd_len;
        cmd_hold  = ~cmd_hold;
        for (int k = 1; k <= kEnd; k++) begin
            @(negedge clk);
            checkOutput($sformatf("req L%0d H%0d k%0d", len, hold, k), int'(req), int'(k <= 2));
            checkOutput($sformatf("done L%0d H%0d k%0d", len, hold, k), int'(done), int'(k == 2 + len));
            checkOutput($sformatf("dly L%0d H%0d k%0d", len, hold, k), int'(dly),
                        int'((hold > 0) && (k >= 2 + len) && (k <= 1 + len + hold)));
            checkOutput($sformatf("gnt L%0d H%0d k%0d", len, hold, k), int'(gnt),
                        int'((k >= 2) && (k <= 2 + len + hold)));
            checkOutput($sformatf("beat L%0d H%0d k%0d", len, hold, k), int'(beat),
                        int'((k >= 2) && (k <= 2 + len)));
            checkOutput($sformatf("busy L%0d H%0d k%0d", len, hold, k), int'(busy), int'(k <= 2 + len + hold));
            checkOutput($sformatf("ready L%0d H%0d k%0d", len, hold, k), int'(cmd_ready), int'(k == kEnd));
            if (k < kEnd) begin
                @(posedge clk);
                #1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int firstDone;
        int secondReq;
        int secondBeat;
        int accepts;
        logic prevReq;

        checks    = 0;
        errors    = 0;
        beatCount = 0;
        rst       = 1'b0;
        useArb    = 1'b1;
        tbGnt     = 1'b0;
        cmd_valid = 1'b0;
        cmd_len   = '0;
        cmd_hold  = '0;

        #2;
        rst = 1'b1;
        #1;
        checkOutput("rstReq", int'(req), 0);
        checkOutput("rstDone", int'(done), 0);
        checkOutput("rstDly", int'(dly), 0);
        checkOutput("rstBeat", int'(beat), 0);
        checkOutput("rstBusy", int'(busy), 0);
        checkOutput("rstBeatIdx", int'(beat_idx), 0);
        checkOutput("rstReady", int'(cmd_ready), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("readyAfterRst", int'(cmd_ready), 1);
        @(posedge clk);
        #1;

        $display("[TB] single beat, no hold");
        applyStimulus(0, 0);
        $display("[TB] burst with hold");
        applyStimulus(3, 2);
        $display("[TB] hold of one");
        applyStimulus(1, 1);
        $display("[TB] full-length burst");
        applyStimulus(15, 7);

        $display("[TB] back-to-back commands");
        firstDone  = -1;
        secondReq  = -1;
        secondBeat = -1;
        accepts    = 0;
        prevReq    = 1'b0;
        cmd_valid  = 1'b1;
        cmd_len    = LEN_W'(1);
        cmd_hold   = '0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done && firstDone < 0) firstDone = c;
            if (firstDone >= 0 && req && !prevReq && secondReq < 0) secondReq = c;
            if (firstDone >= 0 && c > firstDone && beat && secondBeat < 0) secondBeat = c;
            prevReq = req;
            if (cmd_valid && cmd_ready) begin
                pushBurst(1, 0);
                accepts++;
            end
            @(posedge clk);
            #1;
            if (accepts == 2) cmd_valid = 1'b0;
        end
        checkOutput("b2bAccepts", accepts, 2);
        checkOutput("b2bFirstDone", firstDone, 3);
        checkOutput("b2bSecondReq", secondReq, firstDone + 2);
        checkOutput("b2bSecondBeat", secondBeat, firstDone + 3);
        checkOutput("b2bIdle", int'(busy), 0);

        $display("[TB] reset mid-hold");
        cmd_valid = 1'b1;
        cmd_len   = '0;
        cmd_hold  = HOLD_W'(5);
        pushBurst(0, 5);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("rmhDone", int'(done), 1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checkOutput("rmhDlyBefore", int'(dly), 1);
        rst = 1'b1;
        #1;
        checkOutput("rmhDly", int'(dly), 0);
        checkOutput("rmhBusy", int'(busy), 0);
        checkOutput("rmhReq", int'(req), 0);
        checkOutput("rmhGnt", int'(gnt), 0);
        checkOutput("rmhReady", int'(cmd_ready), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("rmhReadyAfter", int'(cmd_ready), 1);
        @(posedge clk);
        #1;
        applyStimulus(2, 1);

        $display("[TB] stall and spurious grant");
        useArb = 1'b0;
        tbGnt  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("idleGntBeat", int'(beat), 0);
            checkOutput("idleGntBusy", int'(busy), 0);
        end
        @(posedge clk);
        #1;
        beatCount = 0;
        tbGnt     = 1'b0;
        cmd_valid = 1'b1;
        cmd_len   = LEN_W'(2);
        cmd_hold  = '0;
        pushBurst(2, 0);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        tbGnt     = 1'b1;
        @(negedge clk);
        checkOutput("stallBeat0", int'(beat), 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("stallBeat1", int'(beat), 1);
        @(posedge clk);
        #1;
        tbGnt = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("stallNoBeat", int'(beat), 0);
            checkOutput("stallIdxHold", int'(beat_idx), 2);
            checkOutput("stallBusy", int'(busy), 1);
            @(posedge clk);
            #1;
        end
        tbGnt = 1'b1;
        @(negedge clk);
        checkOutput("stallLastBeat", int'(beat), 1);
        checkOutput("stallDone", int'(done), 1);
        @(posedge clk);
        #1;
        tbGnt = 1'b0;
        @(negedge clk);
        checkOutput("stallEndBusy", int'(busy), 0);
        checkOutput("stallEndReady", int'(cmd_ready), 1);
        checkOutput("stallBeatCount", beatCount, 3);

        checkOutput("sbEmpty", sbQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
